mem_8byte_arbiter: RTL and testbench
====================================

// Module: mem_8byte_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of memory_8byte. Accepts single-byte
//  read/write requests from two requesters, serialises them onto the memory's active-low
//  strobes (rd_bar/wr_bar/decoder_en), and returns read data with a per-port valid pulse.
//  Guarantees rd_bar and wr_bar are never low together.
// PARAMETERS
//  ADDR_W  3  memory address width (8 locations)
//  DATA_W  8  data width
//  RD_LAT  1  cycles from read strobe to mem_r_data valid; legal range 1..4
// PORTS
//  clk             in   1           rising-edge clock, shared with memory_8byte
//  rst             in   1           synchronous reset, active-high
//  req             in   2           req[k]: port k requests; held until gnt[k]
//  we              in   2           we[k]: 1=write, 0=read; stable while req[k]
//  addr            in   2*ADDR_W    port k address at [k*ADDR_W +: ADDR_W]
//  wdata           in   2*DATA_W    port k write data at [k*DATA_W +: DATA_W]
//  gnt             out  2           one-cycle accept pulse; command latched this edge
//  rvalid          out  2           one-cycle read-data-valid pulse for port k
//  rdata           out  DATA_W      read data, qualified by rvalid; shared by both ports
//  busy            out  1           high in any state other than IDLE
//  mem_addr        out  ADDR_W      to memory addr
//  mem_w_data      out  DATA_W      to memory w_data
//  mem_rd_bar      out  1           to memory rd_bar (active-low)
//  mem_wr_bar      out  1           to memory wr_bar (active-low)
//  mem_decoder_en  out  1           to memory decoder_en (active-high)
//  mem_r_data      in   DATA_W      from memory r_data
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=port0, gnt=0, rvalid=0, rdata=0, busy=0, mem_addr=0,
//   mem_w_data=0, mem_rd_bar=1, mem_wr_bar=1, mem_decoder_en=0. Mid-op reset aborts the
//   transaction: strobes go inactive at that edge, no rvalid, lost request not replayed.
//  FSM IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> IDLE.
//  IDLE: gnt combinational from req and rr pointer; winner's we/addr/wdata latched, go ISSUE.
//   No req: stay IDLE, memory strobes inactive.
//  Round robin: both req -> port at pointer wins; after any grant pointer = other port.
//   Single req wins regardless of pointer. Pointer only moves on grant.
//  ISSUE (1 cycle): mem_decoder_en=1, mem_addr/mem_w_data = latched values;
//   write: mem_wr_bar=0, mem_rd_bar=1; memory captures at end of ISSUE; next IDLE.
//   read: mem_rd_bar=0, mem_wr_bar=1; next WAIT.
//  WAIT (RD_LAT cycles, counter): mem_rd_bar=0, decoder_en=1, addr held. On edge ending
//   last WAIT cycle rdata<=mem_r_data and rvalid[owner]<=1 for exactly one cycle; next IDLE.
//  Latency (grant in cycle N): write strobe cycle N+1; read rvalid cycle N+2+RD_LAT.
//   Throughput: write 2 cycles/op, read 2+RD_LAT cycles/op.
//  rvalid cycle overlaps IDLE, so a new grant may coincide with rvalid (same or other port).
//  gnt never asserted outside IDLE; at most one gnt bit high; req dropped before gnt is
//   ignored; rdata holds last read value between reads.
//  Invariant: {mem_rd_bar,mem_wr_bar} != 2'b00 every cycle, including reset.
// TESTING
//  1 Reset: rst=1 2 cycles -> all outputs at reset values; rd_bar=wr_bar=1, decoder_en=0.
//  2 Port0 write addr=7 data=AA, then port0 read addr=7 -> rvalid[0] at grant+3
//    (RD_LAT=1), rdata=AA; write strobe exactly one cycle.
//  3 Both ports req continuously (p0 wr addr5=1A, p1 rd addr5) -> grants alternate
//    0,1,0,...; p1 read after p0 write returns 1A.
//  4 Single port1 writes addr4=11, addr6=33 back-to-back, reads both -> 11, 33;
//    gnt every 2 cycles for writes; pointer irrelevant.
//  5 rst asserted during WAIT of a port1 read -> no rvalid, strobes inactive next
//    cycle, pointer=port0, new req served normally.
//  6 Every cycle of all tests: assert never rd_bar=0 && wr_bar=0; onehot0(gnt);
//    onehot0(rvalid); RD_LAT=3 rerun of test 2 -> rvalid at grant+5.

Source files
------------

// File: rtl/mem_8byte_arbiter_if.sv
// Bundle between two byte requesters, the arbiter, and the memory_8byte strobes.
// Latency: none, wiring only.
// Backpressure: requesters hold req until gnt; the memory side has no flow control.
interface mem_8byte_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  // requester side
  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  // memory side
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_w_data;
  logic                mem_rd_bar;
  logic                mem_wr_bar;
  logic                mem_decoder_en;
  logic [DATA_W-1:0]   mem_r_data;

  // the arbiter
  modport slave (
    input  req, we, addr, wdata, mem_r_data,
    output gnt, rvalid, rdata, busy,
           mem_addr, mem_w_data, mem_rd_bar, mem_wr_bar, mem_decoder_en
  );

  // requesters plus memory, as seen from outside the arbiter
  modport master (
    output req, we, addr, wdata, mem_r_data,
    input  gnt, rvalid, rdata, busy,
           mem_addr, mem_w_data, mem_rd_bar, mem_wr_bar, mem_decoder_en
  );
endinterface

// File: rtl/mem_8byte_arbiter.sv
// Two-port round-robin sequencer driving memory_8byte's active-low rd/wr strobes.
// Latency: grant in cycle N -> write strobe N+1, read rvalid N+2+RD_LAT.
// Backpressure: one command in flight; gnt is only offered in IDLE, req is held until gnt.
module mem_8byte_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1   // legal 1..4, fits the 2-bit wait counter
) (
  input logic              clk,
  input logic              rst,
  mem_8byte_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  logic [1:0]        r_state;
  logic              r_ptr;      // port that wins when both request
  logic              r_owner;    // port that owns the command in flight
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_cnt;
  logic [1:0]        r_rvalid;

  logic [1:0]        w_gnt;
  logic              w_sel;
  logic              w_active;
  logic              w_issue;

  // Grant decision: only in IDLE and never while reset is held, so a request
  // sitting on the bus during reset is not silently consumed.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst && r_state == S_IDLE) begin
      case (bus.req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_sel    = w_gnt[1];
  assign w_issue  = (r_state == S_ISSUE);
  assign w_active = w_issue || (r_state == S_WAIT);

  // Sequencer: latch the winner, strobe once, wait out the read latency, return data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= 2'd0;
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_owner <= w_sel;
            r_we    <= bus.we[w_sel];
            r_addr  <= w_sel ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
            r_wdata <= w_sel ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
            r_ptr   <= ~w_sel;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 2'd0;
          r_state <= r_we ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == LAST_WAIT) begin
            r_rdata  <= bus.mem_r_data;
            r_rvalid <= r_owner ? 2'b10 : 2'b01;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state; r_we separates the two, so rd_bar and wr_bar
  // can never be low together.
  assign bus.mem_decoder_en = w_active;
  assign bus.mem_rd_bar     = ~(w_active && !r_we);
  assign bus.mem_wr_bar     = ~(w_issue && r_we);
  assign bus.mem_addr       = r_addr;
  assign bus.mem_w_data     = r_wdata;

  assign bus.gnt    = w_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_8byte_arbiter.sv
// Bench: two arbiters (RD_LAT=1 and RD_LAT=3), each with its own memory model,
// checked every cycle against a transaction-schedule model plus directed literal checks.
module tb_mem_8byte_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_8byte_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus_a ();
  mem_8byte_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus_b ();

  mem_8byte_arbiter #(.ADDR_W(3), .DATA_W(8), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  mem_8byte_arbiter #(.ADDR_W(3), .DATA_W(8), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // stimulus arrays, index 0 -> bus_a, 1 -> bus_b
  logic [1:0]  t_req[2];
  logic [1:0]  t_we[2];
  logic [5:0]  t_addr[2];
  logic [15:0] t_wdata[2];

  assign bus_a.req = t_req[0];   assign bus_b.req = t_req[1];
  assign bus_a.we = t_we[0];     assign bus_b.we = t_we[1];
  assign bus_a.addr = t_addr[0]; assign bus_b.addr = t_addr[1];
  assign bus_a.wdata = t_wdata[0]; assign bus_b.wdata = t_wdata[1];

  logic [1:0] s_gnt[2], s_rv[2];
  logic [7:0] s_rdata[2], s_wdat[2];
  logic [2:0] s_maddr[2];
  logic       s_busy[2], s_rd[2], s_wr[2], s_den[2];

  assign s_gnt[0] = bus_a.gnt;        assign s_gnt[1] = bus_b.gnt;
  assign s_rv[0] = bus_a.rvalid;      assign s_rv[1] = bus_b.rvalid;
  assign s_rdata[0] = bus_a.rdata;    assign s_rdata[1] = bus_b.rdata;
  assign s_wdat[0] = bus_a.mem_w_data; assign s_wdat[1] = bus_b.mem_w_data;
  assign s_maddr[0] = bus_a.mem_addr; assign s_maddr[1] = bus_b.mem_addr;
  assign s_busy[0] = bus_a.busy;      assign s_busy[1] = bus_b.busy;
  assign s_rd[0] = bus_a.mem_rd_bar;  assign s_rd[1] = bus_b.mem_rd_bar;
  assign s_wr[0] = bus_a.mem_wr_bar;  assign s_wr[1] = bus_b.mem_wr_bar;
  assign s_den[0] = bus_a.mem_decoder_en; assign s_den[1] = bus_b.mem_decoder_en;

  // memory models: write at end of strobe cycle, read data through an RD_LAT pipe;
  // 8'hEE marks a pipe slot that was not filled by a read strobe
  logic [7:0] mem_a[8], mem_b[8];
  logic [7:0] pa, pb0, pb1, pb2;
  always @(posedge clk) begin
    if (bus_a.mem_decoder_en && !bus_a.mem_wr_bar) mem_a[bus_a.mem_addr] <= bus_a.mem_w_data;
    pa <= (bus_a.mem_decoder_en && !bus_a.mem_rd_bar) ? mem_a[bus_a.mem_addr] : 8'hEE;
    if (bus_b.mem_decoder_en && !bus_b.mem_wr_bar) mem_b[bus_b.mem_addr] <= bus_b.mem_w_data;
    pb0 <= (bus_b.mem_decoder_en && !bus_b.mem_rd_bar) ? mem_b[bus_b.mem_addr] : 8'hEE;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign bus_a.mem_r_data = pa;
  assign bus_b.mem_r_data = pb2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int i);
    total++;
    bad++;
    $display("FAIL %s inst%0d cyc=%0d: got timeout expected event", nm, i, cyc);
  endtask

  // ---------------- schedule model ----------------
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  bit         armed[2]   = '{0, 0};
  bit         ptr[2];
  bit         op_we[2];
  int         free_at[2];
  int         rv_cyc[2]  = '{-1, -1};
  int         rv_port[2];
  logic [7:0] rv_data[2];
  logic [7:0] m_rdata[2];
  logic [2:0] m_addr[2];
  logic [7:0] m_wdata[2];
  logic [7:0] mmem[2][8];
  int         wr_cyc[2]  = '{-1, -1};
  logic [2:0] wr_a[2];
  logic [7:0] wr_d[2];
  logic [1:0] pend_g[2]  = '{2'b00, 2'b00};
  bit         pend_rst   = 1'b1;

  // compare process: expected outputs for the current cycle
  always @(negedge clk) begin
    logic [1:0] g;
    logic [1:0] erv;
    bit         eb;
    for (int i = 0; i < 2; i++) begin
      if (armed[i]) begin
        g = 2'b00;
        if (!rst && cyc >= free_at[i] && t_req[i] != 2'b00) begin
          if (t_req[i] == 2'b11) g = ptr[i] ? 2'b10 : 2'b01;
          else g = t_req[i];
        end
        eb  = (cyc < free_at[i]);
        erv = 2'b00;
        if (cyc == rv_cyc[i]) begin
          erv = (rv_port[i] == 1) ? 2'b10 : 2'b01;
          m_rdata[i] = rv_data[i];
        end
        chk("gnt", i, 32'(s_gnt[i]), 32'(g));
        chk("busy", i, 32'(s_busy[i]), 32'(eb));
        chk("decoder_en", i, 32'(s_den[i]), 32'(eb));
        chk("rd_bar", i, 32'(s_rd[i]), 32'(!(eb && !op_we[i])));
        chk("wr_bar", i, 32'(s_wr[i]), 32'(!(eb && op_we[i])));
        chk("rvalid", i, 32'(s_rv[i]), 32'(erv));
        chk("rdata", i, 32'(s_rdata[i]), 32'(m_rdata[i]));
        chk("mem_addr", i, 32'(s_maddr[i]), 32'(m_addr[i]));
        chk("mem_w_data", i, 32'(s_wdat[i]), 32'(m_wdata[i]));
        chk("strobes_not_both_low", i, 32'(s_rd[i] | s_wr[i]), 32'd1);
        chk("gnt_onehot0", i, 32'($onehot0(s_gnt[i])), 32'd1);
        chk("rvalid_onehot0", i, 32'($onehot0(s_rv[i])), 32'd1);
        pend_g[i] = g;
      end
    end
    pend_rst = rst;
  end

  // model update at the clock edge
  always @(posedge clk) begin
    int p;
    logic [2:0] a;
    logic [7:0] d;
    for (int i = 0; i < 2; i++) begin
      if (wr_cyc[i] == cyc) mmem[i][wr_a[i]] = wr_d[i];
      if (pend_rst) begin
        armed[i] = 1'b1;  ptr[i] = 1'b0;  op_we[i] = 1'b0;
        free_at[i] = cyc + 1;  rv_cyc[i] = -1;  wr_cyc[i] = -1;
        m_rdata[i] = 8'h00;  m_addr[i] = 3'd0;  m_wdata[i] = 8'h00;
      end else if (armed[i] && pend_g[i] != 2'b00) begin
        p = pend_g[i][1] ? 1 : 0;
        a = t_addr[i][p*3 +: 3];
        d = t_wdata[i][p*8 +: 8];
        m_addr[i] = a;  m_wdata[i] = d;  op_we[i] = t_we[i][p];
        ptr[i] = (p == 0);
        if (t_we[i][p]) begin
          free_at[i] = cyc + 2;  wr_cyc[i] = cyc + 1;  wr_a[i] = a;  wr_d[i] = d;
        end else begin
          free_at[i] = cyc + 2 + lat_of(i);
          rv_cyc[i]  = cyc + 2 + lat_of(i);
          rv_port[i] = p;
          rv_data[i] = mmem[i][a];
        end
      end
    end
    cyc++;
  end

  // ---------------- event logs ----------------
  int         wrc[2] = '{0, 0};
  int         gq_port[$];
  int         rq_port[$];
  logic [7:0] rq_data[$];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (!s_wr[i]) wrc[i]++;
    if (|s_gnt[0]) gq_port.push_back(s_gnt[0][1] ? 1 : 0);
    if (|s_rv[0]) begin
      rq_port.push_back(s_rv[0][1] ? 1 : 0);
      rq_data.push_back(s_rdata[0]);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_req(input int i, input int p, input bit w, input logic [2:0] a,
                        input logic [7:0] d, output int gcyc);
    bit ok = 1'b0;
    @(posedge clk); #1;
    t_we[i][p] = w;
    t_addr[i][p*3 +: 3] = a;
    t_wdata[i][p*8 +: 8] = d;
    t_req[i][p] = 1'b1;
    gcyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (s_gnt[i][p]) begin ok = 1'b1; gcyc = cyc; break; end
    end
    if (!ok) fail_now("gnt_wait", i);
    @(posedge clk); #1;
    t_req[i][p] = 1'b0;
  endtask

  task automatic wait_rv(input int i, input int p, output int rc, output logic [7:0] rd);
    bit ok = 1'b0;
    rc = -1; rd = 8'h00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (s_rv[i][p]) begin ok = 1'b1; rc = cyc; rd = s_rdata[i]; break; end
    end
    if (!ok) fail_now("rvalid_wait", i);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int g1, g2, rc, w0, base, gb;
    logic [7:0] rd;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      t_req[i] = 2'b00; t_we[i] = 2'b00; t_addr[i] = 6'd0; t_wdata[i] = 16'd0;
    end

    // reset for two cycles, then check quiescent outputs
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_rd_bar", 0, 32'(bus_a.mem_rd_bar), 32'd1);
    chk("rst_wr_bar", 0, 32'(bus_a.mem_wr_bar), 32'd1);
    chk("rst_decoder_en", 0, 32'(bus_a.mem_decoder_en), 32'd0);
    chk("rst_busy", 0, 32'(bus_a.busy), 32'd0);
    chk("rst_rdata", 0, 32'(bus_a.rdata), 32'd0);
    chk("rst_mem_addr", 0, 32'(bus_a.mem_addr), 32'd0);

    // port0 write 7=AA then read 7, on both latency variants
    for (int i = 0; i < 2; i++) begin
      w0 = wrc[i];
      do_req(i, 0, 1'b1, 3'd7, 8'hAA, g1);
      do_req(i, 0, 1'b0, 3'd7, 8'h00, g2);
      wait_rv(i, 0, rc, rd);
      chk("t2_back_to_back_gap", i, 32'(g2 - g1), 32'd2);
      chk("t2_read_latency", i, 32'(rc - g2), (i == 0) ? 32'd3 : 32'd5);
      chk("t2_read_data", i, 32'(rd), 32'hAA);
      chk("t2_write_strobe_cycles", i, 32'(wrc[i] - w0), 32'd1);
    end

    // both ports requesting continuously: p0 writes 5=1A, p1 reads 5
    pulse_reset();
    base = gq_port.size();
    gb = rq_port.size();
    t_we[0] = 2'b01; t_addr[0] = {3'd5, 3'd5}; t_wdata[0] = {8'h00, 8'h1A};
    t_req[0] = 2'b11;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (gq_port.size() >= base + 4) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1; t_req[0] = 2'b00;
    if (!ok) fail_now("t3_grants", 0);
    else for (int k = 0; k < 4; k++) chk("t3_grant_order", 0, 32'(gq_port[base + k]), 32'(k % 2));
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (rq_port.size() >= gb + 2) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("t3_rvalid", 0);
    else begin
      chk("t3_read_port", 0, 32'(rq_port[gb]), 32'd1);
      chk("t3_read_data", 0, 32'(rq_data[gb]), 32'h1A);
    end

    // single port1 writes 4=11, 6=33 then reads both
    do_req(0, 1, 1'b1, 3'd4, 8'h11, g1);
    do_req(0, 1, 1'b1, 3'd6, 8'h33, g2);
    chk("t4_write_gap", 0, 32'(g2 - g1), 32'd2);
    do_req(0, 1, 1'b0, 3'd4, 8'h00, g1);
    wait_rv(0, 1, rc, rd);
    chk("t4_read4", 0, 32'(rd), 32'h11);
    do_req(0, 1, 1'b0, 3'd6, 8'h00, g1);
    wait_rv(0, 1, rc, rd);
    chk("t4_read6", 0, 32'(rd), 32'h33);

    // reset during the WAIT of a port1 read
    gb = rq_port.size();
    do_req(0, 1, 1'b0, 3'd6, 8'h00, g1);
    @(posedge clk); #1; rst = 1'b1;          // cycle g1+2: WAIT
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    chk("t5_rd_bar_after_rst", 0, 32'(bus_a.mem_rd_bar), 32'd1);
    chk("t5_den_after_rst", 0, 32'(bus_a.mem_decoder_en), 32'd0);
    repeat (4) @(negedge clk);
    #1 chk("t5_no_rvalid", 0, 32'(rq_port.size() - gb), 32'd0);
    @(posedge clk); #1;
    t_we[0] = 2'b00; t_addr[0] = {3'd6, 3'd7}; t_req[0] = 2'b11;
    @(negedge clk); #1;
    chk("t5_ptr_port0", 0, 32'(bus_a.gnt), 32'h1);
    @(posedge clk); #1; t_req[0] = 2'b10;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (s_gnt[0][1]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1; t_req[0] = 2'b00;
    if (!ok) fail_now("t5_p1_gnt", 0);
    wait_rv(0, 1, rc, rd);
    chk("t5_served_data", 0, 32'(rd), 32'h33);

    repeat (6) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
